count_wrap_monitor: RTL and testbench
=====================================

// Module: count_wrap_monitor
// PURPOSE
//   Downstream observer of the up/down preload counter. Samples the counter's
//   count and data_load_f each clock and classifies every change as an up-step,
//   down-step or jump (load/clear). Emits single-cycle wrap and threshold-match
//   pulses, and keeps a saturating wrap tally for the control logic.
// PARAMETERS
//   BIT     4  width of observed count; must be >= 2
//   WRAP_W  8  width of wrap tally wrap_cnt
// PORTS
//   clk          in   1       rising-edge clock, shared with the counter
//   clr          in   1       synchronous active-high reset
//   count        in   BIT     counter value under observation
//   data_load_f  in   1       counter "preload done" flag; 1 = counter running
//   thresh       in   BIT     match value; sampled every cycle
//   match_pulse  out  1       1-cycle pulse: count arrived at thresh
//   wrap_up      out  1       1-cycle pulse: step MAX -> 0
//   wrap_dn      out  1       1-cycle pulse: step 0 -> MAX
//   jump_pulse   out  1       1-cycle pulse: non-unit change (load/clear)
//   dir          out  1       direction of last unit step; 1 = up, 0 = down
//   wrap_cnt     out  WRAP_W  wraps (up + down) since tracking began; saturates
//   wrap_sat     out  1       1 while wrap_cnt is at its all-ones maximum
//   tracking     out  1       1 in TRACK/SAT states
// BEHAVIOUR
//   - Every output is a register. clr=1 at a posedge forces state IDLE and sets
//     all outputs and prev to 0; clr wins over every other condition.
//   - MAX = 2**BIT-1. prev holds the count sampled at the previous edge.
//     Arithmetic is modulo 2**BIT.
//   - IDLE: pulses 0. On a posedge with data_load_f=1: prev<=count,
//     wrap_cnt<=0, wrap_sat<=0, go TRACK. No classification on the entry edge.
//   - TRACK: at each posedge compare count (c) with prev (p), then prev<=c:
//       c==p                 -> no pulse
//       c==p+1               -> dir<=1; wrap_up<=1 if p==MAX
//       c==p-1               -> dir<=0; wrap_dn<=1 if p==0
//       otherwise            -> jump_pulse<=1; dir unchanged; no wrap
//     match_pulse<=1 iff c==thresh and c!=p (arrival, not dwell); a jump
//     that lands on thresh also matches.
//     A wrap increments wrap_cnt. Reaching all-ones sets wrap_sat and moves
//     to SAT.
//   - SAT: same classification and pulses; wrap_cnt frozen at all-ones;
//     wrap_sat=1.
//   - TRACK/SAT with data_load_f=0 at a posedge: go IDLE. No classification
//     on that edge; pulses 0. wrap_cnt/wrap_sat/dir hold until the next IDLE
//     exit.
//   - Latency: a change visible on count before edge k gives pulses high for
//     exactly the cycle after edge k.
//   - Simultaneous events: wrap and match may pulse in the same cycle. Pulses
//     never last more than 1 cycle unless count changes again on the next edge.
// TESTING (BIT=4, WRAP_W=2 unless noted)
//   1 clr=1 for 2 edges while count toggles -> all outputs 0, tracking=0.
//   2 data_load_f 0->1 with count=3, then count 4,5,...,15,0,1 -> tracking=1;
//     dir=1; wrap_up 1 cycle after 15->0 sampled; wrap_cnt=1; no jump.
//   3 TRACK with count 2,1,0,15,14, thresh=15 -> dir=0; wrap_dn and
//     match_pulse in the same cycle; count held at 14 for 3 edges -> no more
//     pulses.
//   4 TRACK with count 6 -> 10 (reload) -> jump_pulse 1 cycle; dir unchanged;
//     wrap_cnt unchanged. Count 6 -> 0 with thresh=0 -> jump_pulse and
//     match_pulse both high.
//   5 Four up-wraps with WRAP_W=2 -> wrap_cnt=3 after third; wrap_sat=1; SAT;
//     fourth wrap still pulses wrap_up; wrap_cnt stays 3.
//   6 data_load_f 1->0 mid-count -> IDLE, wrap_cnt holds; data_load_f 1
//     again -> wrap_cnt=0. clr mid-TRACK -> all 0 on next edge.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// rtl/count_wrap_monitor.sv - step/wrap/jump classifier for an up/down preload counter
//
// Purpose:
//   Watches a counter's value each clock and classifies every change as a unit
//   up-step, unit down-step or jump (load/clear). Emits single-cycle wrap,
//   jump and threshold-arrival pulses and keeps a saturating wrap tally.
//
// Ports:
//   clk          in   rising-edge clock, shared with the counter
//   clr          in   synchronous active-high reset
//   count        in   [BIT-1:0] counter value under observation
//   data_load_f  in   1 = counter running (preload done)
//   thresh       in   [BIT-1:0] match value, sampled every cycle
//   match_pulse  out  1-cycle pulse: count arrived at thresh
//   wrap_up      out  1-cycle pulse: step MAX -> 0
//   wrap_dn      out  1-cycle pulse: step 0 -> MAX
//   jump_pulse   out  1-cycle pulse: non-unit change
//   dir          out  direction of last unit step (1 = up)
//   wrap_cnt     out  [WRAP_W-1:0] saturating wrap tally since tracking began
//   wrap_sat     out  1 while wrap_cnt is all-ones
//   tracking     out  1 in TRACK/SAT states

module count_wrap_monitor #(
  parameter int BIT    = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [BIT-1:0]    count,
  input  logic              data_load_f,
  input  logic [BIT-1:0]    thresh,
  output logic              match_pulse,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              jump_pulse,
  output logic              dir,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_sat,
  output logic              tracking
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    SAT   = 2'd2
  } state_t;

  localparam logic [BIT-1:0]    CNT_MAX  = {BIT{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_t            state_q, state_d;
  logic [BIT-1:0]    prev_q, prev_d;
  logic              match_q, match_d;
  logic              wrap_up_q, wrap_up_d;
  logic              wrap_dn_q, wrap_dn_d;
  logic              jump_q, jump_d;
  logic              dir_q, dir_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_sat_q, wrap_sat_d;
  logic              tracking_q, tracking_d;

  // Modulo-2**BIT neighbours of the previous sample.
  logic [BIT-1:0]    prev_inc, prev_dec;
  logic [WRAP_W-1:0] wrap_inc;

  assign prev_inc = prev_q + BIT'(1);
  assign prev_dec = prev_q - BIT'(1);
  assign wrap_inc = wrap_cnt_q + WRAP_W'(1);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = 1'b0;
    wrap_up_d  = 1'b0;
    wrap_dn_d  = 1'b0;
    jump_d     = 1'b0;
    dir_d      = dir_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_sat_d = wrap_sat_q;

    case (state_q)
      IDLE: begin
        // Entry edge only captures the baseline; nothing is classified.
        if (data_load_f) begin
          prev_d     = count;
          wrap_cnt_d = '0;
          wrap_sat_d = 1'b0;
          state_d    = TRACK;
        end
      end

      TRACK, SAT: begin
        if (!data_load_f) begin
          // Leaving: tally, saturation flag and dir stay visible while idle.
          state_d = IDLE;
        end else begin
          prev_d = count;
          if (count == prev_q) begin
            // dwell: no pulse
          end else if (count == prev_inc) begin
            dir_d     = 1'b1;
            wrap_up_d = (prev_q == CNT_MAX);
          end else if (count == prev_dec) begin
            dir_d     = 1'b0;
            wrap_dn_d = (prev_q == '0);
          end else begin
            jump_d = 1'b1;
          end

          // Arrival only; a jump that lands on thresh counts as arrival.
          match_d = (count == thresh) && (count != prev_q);

          // In SAT the tally is frozen at all-ones.
          if ((wrap_up_d || wrap_dn_d) && state_q == TRACK) begin
            wrap_cnt_d = wrap_inc;
            if (wrap_inc == WRAP_MAX) begin
              wrap_sat_d = 1'b1;
              state_d    = SAT;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    tracking_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      match_q    <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      jump_q     <= 1'b0;
      dir_q      <= 1'b0;
      wrap_cnt_q <= '0;
      wrap_sat_q <= 1'b0;
      tracking_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      wrap_up_q  <= wrap_up_d;
      wrap_dn_q  <= wrap_dn_d;
      jump_q     <= jump_d;
      dir_q      <= dir_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_sat_q <= wrap_sat_d;
      tracking_q <= tracking_d;
    end
  end

  assign match_pulse = match_q;
  assign wrap_up     = wrap_up_q;
  assign wrap_dn     = wrap_dn_q;
  assign jump_pulse  = jump_q;
  assign dir         = dir_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign wrap_sat    = wrap_sat_q;
  assign tracking    = tracking_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb/tb_count_wrap_monitor.sv - scoreboard bench for count_wrap_monitor (BIT=4, WRAP_W=2)

module tb_count_wrap_monitor;

  logic       clk;
  logic       clr;
  logic [3:0] count;
  logic       data_load_f;
  logic [3:0] thresh;
  logic       match_pulse, wrap_up, wrap_dn, jump_pulse, dir, wrap_sat, tracking;
  logic [1:0] wrap_cnt;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Expected vector: {match, wrap_up, wrap_dn, jump, dir, wrap_cnt[1:0], wrap_sat, tracking}
  logic [8:0] exp_q[$];

  count_wrap_monitor #(.BIT(4), .WRAP_W(2)) dut (
    .clk(clk),
    .clr(clr),
    .count(count),
    .data_load_f(data_load_f),
    .thresh(thresh),
    .match_pulse(match_pulse),
    .wrap_up(wrap_up),
    .wrap_dn(wrap_dn),
    .jump_pulse(jump_pulse),
    .dir(dir),
    .wrap_cnt(wrap_cnt),
    .wrap_sat(wrap_sat),
    .tracking(tracking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic s(input logic c, input logic dl, input logic [3:0] cn, input logic [3:0] th,
                   input logic m, input logic u, input logic d, input logic j, input logic dr,
                   input logic [1:0] wc, input logic st, input logic tk);
    @(negedge clk);
    clr         = c;
    data_load_f = dl;
    count       = cn;
    thresh      = th;
    exp_q.push_back({m, u, d, j, dr, wc, st, tk});
  endtask

  // Monitor: outputs are registered, so every edge presents a new result.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [8:0] e, a;
      e = exp_q.pop_front();
      a = {match_pulse, wrap_up, wrap_dn, jump_pulse, dir, wrap_cnt, wrap_sat, tracking};
      step_no++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d {match,wup,wdn,jump,dir,wcnt,sat,trk} got %b want %b", step_no, a, e);
      end
    end
  end

  initial begin
    clr = 1'b1; data_load_f = 1'b0; count = 4'd0; thresh = 4'd9;

    // 1: clear dominates while count toggles and data_load_f is high
    s(1,0,5,9, 0,0,0,0,0,2'd0,0,0);
    s(1,1,6,9, 0,0,0,0,0,2'd0,0,0);
    s(0,0,3,9, 0,0,0,0,0,2'd0,0,0);

    // 2: entry at 3, count up through 15 -> 0 -> 1; match on arrival at 9
    s(0,1,3,9, 0,0,0,0,0,2'd0,0,1);
    for (int c = 4; c <= 15; c++)
      s(0,1,4'(c),9, (c == 9),0,0,0,1,2'd0,0,1);
    s(0,1,0,9, 0,1,0,0,1,2'd1,0,1);
    s(0,1,1,9, 0,0,0,0,1,2'd1,0,1);

    // 3: down through 0 -> 15 with thresh=15, then dwell at 14
    s(0,1,2,15,  0,0,0,0,1,2'd1,0,1);
    s(0,1,1,15,  0,0,0,0,0,2'd1,0,1);
    s(0,1,0,15,  0,0,0,0,0,2'd1,0,1);
    s(0,1,15,15, 1,0,1,0,0,2'd2,0,1);
    s(0,1,14,15, 0,0,0,0,0,2'd2,0,1);
    for (int k = 0; k < 3; k++)
      s(0,1,14,15, 0,0,0,0,0,2'd2,0,1);

    // 4: jumps keep dir and tally; jump landing on thresh also matches; dwell on thresh does not
    s(0,1,6,15,  0,0,0,1,0,2'd2,0,1);
    s(0,1,10,15, 0,0,0,1,0,2'd2,0,1);
    s(0,1,11,15, 0,0,0,0,1,2'd2,0,1);
    s(0,1,6,0,   0,0,0,1,1,2'd2,0,1);
    s(0,1,0,0,   1,0,0,1,1,2'd2,0,1);
    s(0,1,0,0,   0,0,0,0,1,2'd2,0,1);

    // 5a: third wrap (down) saturates; further wraps pulse but tally frozen
    s(0,1,15,8, 0,0,1,0,0,2'd3,1,1);
    s(0,1,0,8,  0,1,0,0,1,2'd3,1,1);
    s(0,1,14,8, 0,0,0,1,1,2'd3,1,1);
    s(0,1,15,8, 0,0,0,0,1,2'd3,1,1);
    s(0,1,0,8,  0,1,0,0,1,2'd3,1,1);

    // 6a: leave tracking mid-count; tally, sat and dir hold
    s(0,0,5,8, 0,0,0,0,1,2'd3,1,0);
    s(0,0,7,8, 0,0,0,0,1,2'd3,1,0);
    // re-entry clears tally
    s(0,1,2,8, 0,0,0,0,1,2'd0,0,1);

    // 5b: four up-wraps from a fresh tally
    s(0,1,15,8, 0,0,0,1,1,2'd0,0,1);
    s(0,1,0,8,  0,1,0,0,1,2'd1,0,1);
    for (int k = 1; k <= 3; k++) begin
      s(0,1,7,8,  0,0,0,1,1,2'(k),(k == 3),1);
      s(0,1,15,8, 0,0,0,1,1,2'(k),(k == 3),1);
      s(0,1,0,8,  0,1,0,0,1,(k >= 2) ? 2'd3 : 2'(k + 1),(k >= 2),1);
    end

    // 6b: clr mid-track clears everything, then re-entry
    s(1,1,4,8, 0,0,0,0,0,2'd0,0,0);
    s(0,1,4,8, 0,0,0,0,0,2'd0,0,1);
    s(0,1,5,8, 0,0,0,0,1,2'd0,0,1);

    // Let the monitor drain the queue, with a bound.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
